serial_add_sub: RTL
===================

Name: serial_add_sub

Overview:
- Bit-serial adder/subtractor for the datapath lab.
- Runs the carry chain in time instead of space. Operands are loaded on a start pulse and processed LSB-first with one full-adder and one carry flip-flop, one bit per clock.
- A done pulse marks the result.
- Sits beside the combinational ripple-carry adder as its area-minimal, multi-cycle counterpart. It also adds the subtract direction.

Parameters:
WIDTH, 3, operand/result width in bits (legal range >= 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
sub  input  1  0 = a+b+cin, 1 = a-b-cin; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
cin  input  1  carry-in (add) / borrow-in (sub); sampled with start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  sum/difference, held until the next completion
cout  output  1  add: carry-out; sub: no-borrow (1 when a >= b+cin, unsigned)

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low.
  - On rst_n=0: state=IDLE, busy=0, done=0, result=0, cout=0, bit counter=0, internal shift/carry registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at a rising edge: load A shift register with a.
  - Load B shift register with b if sub=0, else with ~b.
  - Load carry FF with cin if sub=0, else with ~cin. This makes a-b-cin = a + ~b + ~cin.
  - Clear the counter and go to SHIFT.
- SHIFT:
  - busy=1.
  - Each edge: s = A[0]^B[0]^c; c <= majority(A[0],B[0],c).
  - Shift A and B right by one.
  - Shift s into the MSB of the internal sum register.
  - Increment the counter.
  - On the edge processing bit WIDTH-1: copy the sum register (with s) to result, copy the new carry to cout, go to DONE.
- DONE:
  - done=1, busy=0, for exactly one cycle.
  - Next edge returns to IDLE unconditionally. start is ignored in DONE.
- Latency:
  - If start is sampled at edge N, busy is high from edge N+1 through edge N+WIDTH.
  - done is high in the cycle after edge N+WIDTH.
  - A new start is accepted at edge N+WIDTH+2 at the earliest.
- Output stability:
  - result and cout change only on the edge entering DONE.
  - They hold their value through IDLE and SHIFT of later operations until the next completion.
- Operands: a, b, sub and cin may change freely after the start edge without affecting the operation in progress.
- start held high: one operation per pass through IDLE. A continuously-high start re-launches at each IDLE cycle, i.e. back-to-back every WIDTH+2 cycles.
- start during SHIFT/DONE: ignored, no queueing.
- Reset mid-operation: immediate abort to reset values. No done pulse is produced for the aborted operation.
- Arithmetic:
  - Modulo 2^WIDTH unsigned.
  - Counter width is $clog2(WIDTH+1).
  - WIDTH=1 completes in one SHIFT cycle.

Optional Feature:
OVERFLOW_FLAG_EN
- Defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB, captured on the final SHIFT edge alongside result/cout.
  - Held with result. Reset value 0.
- Undefined:
  - Port ovf and its logic do not exist.
  - All other behaviour is identical.

Test Plan (WIDTH=3):
- Reset with rst_n=0 mid-clock (asynchronous) -> busy=0, done=0, result=000, cout=0 immediately, before any clock edge.
- Add cases:
  - start, sub=0, a=000, b=000, cin=0 -> after 3 busy cycles, done pulse; result=000, cout=0.
  - a=001, b=010, cin=0 -> result=011, cout=0.
  - a=111, b=111, cin=1 -> result=111, cout=1. With OVERFLOW_FLAG_EN: ovf=0.
- Subtract cases:
  - sub=1, a=101, b=011, cin=0 -> result=010, cout=1.
  - sub=1, a=010, b=011, cin=0 -> result=111, cout=0.
  - sub=1, a=000, b=000, cin=1 -> result=111, cout=0.
- Signed overflow (OVERFLOW_FLAG_EN): sub=0, a=011, b=001, cin=0 -> result=100, cout=0, ovf=1.
- Protocol:
  - Pulse start again during SHIFT with different operands -> ignored; first result unchanged.
  - Exactly one done pulse per accepted start.
  - Operands changed after the start edge do not alter the result.
- Reset mid-operation: assert rst_n=0 during the second SHIFT cycle -> immediate reset values, no done pulse.
  - After release, a new start with a=001, b=001 -> result=010.

Source files
------------

// File: rtl/serial_add_sub.sv
// ----------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial adder/subtractor. Operands are captured on a start pulse in
//   IDLE and processed LSB-first through a single full-adder and carry FF,
//   one bit per clock. A one-cycle done pulse marks the new result.
//   Subtraction is performed as a + ~b + ~cin.
//
// Parameters:
//   WIDTH   operand/result width in bits (>= 1)
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request pulse, sampled only in IDLE
//   sub     in   0 = a+b+cin, 1 = a-b-cin (sampled with start)
//   a, b    in   operands (sampled with start)
//   cin     in   carry-in / borrow-in (sampled with start)
//   busy    out  high while bits are being processed
//   done    out  one-cycle pulse, result valid
//   result  out  sum/difference, held until the next completion
//   cout    out  add: carry-out; sub: no-borrow (a >= b+cin)
//   ovf     out  signed overflow, only when OVERFLOW_FLAG_EN is defined
//
// Build option:
//   OVERFLOW_FLAG_EN  adds the ovf output (carry into MSB ^ carry out of MSB)
// ----------------------------------------------------------------------------
module serial_add_sub #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             carry_next;
    logic             s_bit;
    logic             last_bit;

    // Single full-adder slice; the sum bit enters the sum register from the top
    // so that after WIDTH shifts bit 0 holds the LSB.
    always_comb begin
        s_bit      = a_sr[0] ^ b_sr[0] ^ carry;
        carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        sum_next   = sum_sr >> 1;
        sum_next[WIDTH-1] = s_bit;
        last_bit   = (cnt == LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= carry_next;
                    sum_sr <= sum_next;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        result <= sum_next;
                        cout   <= carry_next;
`ifdef OVERFLOW_FLAG_EN
                        // carry is the carry into the MSB at this point
                        ovf    <= carry ^ carry_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
